// File: rtl/go_done_scheduler_pkg.sv
// go_done_sched_pkg: shared types and helpers for the go/done scheduler.
package go_done_sched_pkg;

  // Scheduler phases: component reset, waiting for work, component running,
  // one-cycle completion report.
  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_RUN     = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  localparam int DEFAULT_RESET_CYCLES = 5;

  // Width of a requester index; never below one bit.
  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/go_done_scheduler_if.sv
// go_done_scheduler_if: requester-side and component-side handshake bundle.
// master = the scheduler, slave = requesters plus the shared component.
interface go_done_scheduler_if
  import go_done_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LIMIT_W = 32
) ();
  localparam int IDW = idw(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] ack;
  logic               err;
  logic [IDW-1:0]     grant_id;
  logic               busy;
  logic [LIMIT_W-1:0] timeout_limit;
  logic               comp_reset;
  logic               comp_go;
  logic               comp_done;

  modport master (
    input  req, timeout_limit, comp_done,
    output ack, err, grant_id, busy, comp_reset, comp_go
  );

  modport slave (
    output req, timeout_limit, comp_done,
    input  ack, err, grant_id, busy, comp_reset, comp_go
  );
endinterface

// File: rtl/go_done_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. Returns the first set request
// at or after ptr, wrapping modulo NUM_REQ, plus a valid flag.
module rr_arbiter
  import go_done_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = idw(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [IDW-1:0]     idx,
  output logic               valid
);

  // Scan upward from ptr and keep the first requester found.
  always_comb begin
    int             cand;
    logic [IDW-1:0] cand_idx;
    cand     = 0;
    cand_idx = '0;
    idx      = '0;
    valid    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end else begin
        cand = cand;
      end
      cand_idx = IDW'(cand);
      if (!valid && req[cand_idx]) begin
        valid = 1'b1;
        idx   = cand_idx;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/go_done_scheduler.sv
// go_done_scheduler: shares one go/done component among NUM_REQ requesters.
// Holds the component in reset after power-up and after a watchdog timeout,
// grants round-robin, drives go until done or until the latched cycle limit.
// Optional build macro: CYCLE_COUNT_EN adds the 64-bit run_cycles port.
module go_done_scheduler
  import go_done_sched_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int RESET_CYCLES = DEFAULT_RESET_CYCLES,
  parameter int LIMIT_W      = 32
) (
  input  logic                clk,
  input  logic                reset,
  go_done_scheduler_if.master bus
`ifdef CYCLE_COUNT_EN
  ,
  output logic signed [63:0]  run_cycles
`endif
);

  localparam int                 IDW       = idw(NUM_REQ);
  localparam logic [7:0]         INIT_LAST = 8'(RESET_CYCLES - 1);
  localparam logic [IDW-1:0]     LAST_ID   = IDW'(NUM_REQ - 1);
  localparam logic [IDW-1:0]     ID_ONE    = IDW'(32'd1);
  localparam logic [NUM_REQ-1:0] ACK_ONE   = NUM_REQ'(32'd1);
  localparam logic [LIMIT_W-1:0] RUN_ONE   = LIMIT_W'(32'd1);

  state_e             state_r, state_s;
  logic [7:0]         init_cnt_r, init_cnt_s;
  logic [LIMIT_W-1:0] limit_r, limit_s;
  logic [LIMIT_W-1:0] run_cnt_r, run_cnt_s;
  logic [IDW-1:0]     ptr_r, ptr_s;
  logic [IDW-1:0]     grant_r, grant_s;
  logic [NUM_REQ-1:0] ack_r, ack_s;
  logic               err_r, err_s;
  logic               busy_r, busy_s;
  logic               comp_reset_r, comp_reset_s;
  logic               comp_go_r, comp_go_s;
  logic [IDW-1:0]     pick_idx_s;
  logic               pick_valid_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (bus.req),
    .ptr   (ptr_r),
    .idx   (pick_idx_s),
    .valid (pick_valid_s)
  );

  // Next-state and next-output logic; outputs follow the next state so they
  // are valid from the first cycle of each phase.
  always_comb begin
    state_s    = state_r;
    init_cnt_s = init_cnt_r;
    limit_s    = limit_r;
    run_cnt_s  = run_cnt_r;
    ptr_s      = ptr_r;
    grant_s    = grant_r;
    ack_s      = '0;
    err_s      = 1'b0;
    case (state_r)
      ST_INIT: begin
        if (init_cnt_r >= INIT_LAST) begin
          state_s    = ST_IDLE;
          init_cnt_s = 8'd0;
        end else begin
          init_cnt_s = init_cnt_r + 8'd1;
        end
      end
      ST_IDLE: begin
        if (pick_valid_s) begin
          state_s   = ST_RUN;
          grant_s   = pick_idx_s;
          limit_s   = bus.timeout_limit;
          run_cnt_s = RUN_ONE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        // done has priority over a watchdog hit in the same cycle
        if (bus.comp_done) begin
          state_s = ST_RELEASE;
          ack_s   = ACK_ONE << grant_r;
        end else if ((limit_r != '0) && (run_cnt_r == limit_r)) begin
          state_s = ST_RELEASE;
          ack_s   = ACK_ONE << grant_r;
          err_s   = 1'b1;
        end else if (run_cnt_r != '1) begin
          run_cnt_s = run_cnt_r + RUN_ONE;
        end else begin
          run_cnt_s = run_cnt_r;
        end
      end
      ST_RELEASE: begin
        ptr_s = (grant_r == LAST_ID) ? '0 : grant_r + ID_ONE;
        // err_r still holds this invocation's timeout flag
        if (err_r) begin
          state_s    = ST_INIT;
          init_cnt_s = 8'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s    = ST_INIT;
        init_cnt_s = 8'd0;
      end
    endcase
    comp_reset_s = (state_s == ST_INIT);
    comp_go_s    = (state_s == ST_RUN);
    busy_s       = (state_s != ST_IDLE);
  end

  // State and output registers; reset abandons any invocation silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_INIT;
      init_cnt_r   <= 8'd0;
      limit_r      <= '0;
      run_cnt_r    <= '0;
      ptr_r        <= '0;
      grant_r      <= '0;
      ack_r        <= '0;
      err_r        <= 1'b0;
      busy_r       <= 1'b1;
      comp_reset_r <= 1'b1;
      comp_go_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      init_cnt_r   <= init_cnt_s;
      limit_r      <= limit_s;
      run_cnt_r    <= run_cnt_s;
      ptr_r        <= ptr_s;
      grant_r      <= grant_s;
      ack_r        <= ack_s;
      err_r        <= err_s;
      busy_r       <= busy_s;
      comp_reset_r <= comp_reset_s;
      comp_go_r    <= comp_go_s;
    end
  end

  assign bus.ack        = ack_r;
  assign bus.err        = err_r;
  assign bus.grant_id   = grant_r;
  assign bus.busy       = busy_r;
  assign bus.comp_reset = comp_reset_r;
  assign bus.comp_go    = comp_go_r;

`ifdef CYCLE_COUNT_EN
  logic signed [63:0] free_cnt_r, free_cnt_s;
  logic [LIMIT_W-1:0] shadow_r, shadow_s;
  logic signed [63:0] run_cycles_r, run_cycles_s;

  // Free-running count of non-INIT cycles; shadow captures the RUN length
  // of each finishing invocation; the port shows the shadow while idle.
  always_comb begin
    free_cnt_s   = (state_r != ST_INIT) ? free_cnt_r + 64'sd1 : free_cnt_r;
    shadow_s     = (ack_s != '0) ? run_cnt_r : shadow_r;
    run_cycles_s = busy_s ? free_cnt_s : $signed(64'(shadow_s));
  end

  // Cycle-count registers, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      free_cnt_r   <= 64'sd0;
      shadow_r     <= '0;
      run_cycles_r <= 64'sd0;
    end else begin
      free_cnt_r   <= free_cnt_s;
      shadow_r     <= shadow_s;
      run_cycles_r <= run_cycles_s;
    end
  end

  assign run_cycles = run_cycles_r;
`endif

endmodule

// File: tb/tb_go_done_scheduler.sv
// tb_go_done_scheduler: directed scenarios plus a randomized phase checked
// against a transaction-level model of arbitration order, watchdog outcome
// and phase lengths.
module tb_go_done_scheduler;
  import go_done_sched_pkg::*;

  localparam int N    = 4;
  localparam int RC   = 5;
  localparam int LW   = 32;
  localparam int RR_D = 3;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // Cycle stamp, read only at negedges.
  always @(posedge clk) cyc <= cyc + 1;

  go_done_scheduler_if #(.NUM_REQ(N), .LIMIT_W(LW)) bus ();

`ifdef CYCLE_COUNT_EN
  logic signed [63:0] run_cycles;
`endif

  go_done_scheduler #(.NUM_REQ(N), .RESET_CYCLES(RC), .LIMIT_W(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef CYCLE_COUNT_EN
    ,
    .run_cycles (run_cycles)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Round-robin rule: first pending requester at or after p, wrapping.
  function automatic int rr_pick(input logic [N-1:0] m, input int p);
    logic [N-1:0] rot;
    for (int i = 0; i < N; i++) begin
      rot = m >> ((p + i) % N);
      if (rot[0]) return (p + i) % N;
    end
    return -1;
  endfunction

  // One invocation, called at an IDLE negedge. The component model raises
  // done during its done_at-th go cycle (0 = never).
  task automatic do_invocation(input logic [N-1:0] req_v, input int lim, input int done_at,
                               input int exp_id, input bit exp_err, input int exp_go,
                               input bit drop_mid, input bit keep, output int ack_cyc);
    int           waited;
    int           go_cnt;
    logic [N-1:0] me;
    me = N'(32'd1) << exp_id;
    bus.req           = req_v;
    bus.timeout_limit = LW'(lim);
    bus.comp_done     = 1'b0;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus.comp_go && waited < 40);
    check_eq("req_to_go", 64'(waited), 64'd1);
    check_eq("grant_id", 64'(bus.grant_id), 64'(exp_id));
    go_cnt = 1;
    bus.timeout_limit = $urandom;
    if (drop_mid) bus.req = bus.req & ~me;
    bus.comp_done = (go_cnt == done_at);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus.ack != '0 || !bus.comp_go) break;
      go_cnt++;
      bus.comp_done = (go_cnt == done_at);
    end
    check_eq("ack", 64'(bus.ack), 64'(me));
    check_eq("err", 64'(bus.err), 64'(exp_err));
    check_eq("go_cycles", 64'(go_cnt), 64'(exp_go));
    check_eq("go_low_at_ack", 64'(bus.comp_go), 64'd0);
    check_eq("busy_release", 64'(bus.busy), 64'd1);
    bus.comp_done = 1'b0;
    bus.req = keep ? (bus.req | me) : (bus.req & ~me);
    ack_cyc = cyc;
  endtask

  // After an ack: count comp_reset cycles until IDLE; done is driven high
  // meanwhile and must be ignored.
  task automatic check_rereset(input int exp_len);
    int n;
    n = 0;
    @(negedge clk);
    check_eq("ack_one_cycle", 64'(bus.ack), 64'd0);
    check_eq("err_one_cycle", 64'(bus.err), 64'd0);
    for (int k = 0; k < 40; k++) begin
      if (!bus.busy) break;
      if (bus.comp_reset) n++;
      bus.comp_done = 1'b1;
      @(negedge clk);
    end
    bus.comp_done = 1'b0;
    check_eq("rereset_len", 64'(n), 64'(exp_len));
    check_eq("idle_after", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] pend_m;
    int           ptr_m;
    int           ack_c;
    int           prev_c;
    int           n;
    int           acks;
    bit           go_seen;

    reset             = 1'b0;
    bus.req           = '0;
    bus.timeout_limit = '0;
    bus.comp_done     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_comp_reset", 64'(bus.comp_reset), 64'd1);
    check_eq("rst_comp_go", 64'(bus.comp_go), 64'd0);
    check_eq("rst_busy", 64'(bus.busy), 64'd1);
    check_eq("rst_ack", 64'(bus.ack), 64'd0);
    check_eq("rst_err", 64'(bus.err), 64'd0);
    check_eq("rst_grant", 64'(bus.grant_id), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    n = 0;
    go_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.comp_go) go_seen = 1'b1;
      if (!bus.comp_reset) break;
      n++;
    end
    check_eq("init_len", 64'(n), 64'(RC));
    check_eq("init_busy_idle", 64'(bus.busy), 64'd0);
    check_eq("init_no_go", 64'(go_seen), 64'd0);

    // single request, done on the 10th go cycle
    do_invocation(4'b0010, 0, 10, 1, 1'b0, 10, 1'b0, 1'b0, ack_c);
    check_rereset(0);
    // timeout after 8 go cycles, component re-reset
    do_invocation(4'b0001, 8, 0, 0, 1'b1, 8, 1'b0, 1'b0, ack_c);
    check_rereset(RC);
    // done and limit in the same cycle: done wins
    do_invocation(4'b0100, 6, 6, 2, 1'b0, 6, 1'b0, 1'b0, ack_c);
    check_rereset(0);

    // randomized phase against the transaction model
    ptr_m  = 3;
    pend_m = '0;
    for (int it = 0; it < 30; it++) begin
      int d;
      int lim;
      int id;
      bit e;
      bit keep;
      bit drop;
      pend_m = pend_m | N'($urandom_range(0, 15));
      if (pend_m == '0) pend_m = N'(32'd1) << $urandom_range(0, N - 1);
      d    = $urandom_range(1, 20);
      lim  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 14);
      id   = rr_pick(pend_m, ptr_m);
      e    = (lim != 0) && (lim < d);
      keep = 1'($urandom_range(0, 1));
      drop = 1'($urandom_range(0, 1));
      do_invocation(pend_m, lim, d, id, e, e ? lim : d, drop, keep, ack_c);
      ptr_m = (id + 1) % N;
      if (!keep) pend_m = pend_m & ~(N'(32'd1) << id);
      check_rereset(e ? RC : 0);
    end

    // asynchronous reset during the 3rd go cycle
    bus.req = 4'b0100;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.comp_go && n < 10);
    check_eq("mid_go_started", 64'(bus.comp_go), 64'd1);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_eq("mid_rst_go", 64'(bus.comp_go), 64'd0);
    check_eq("mid_rst_comp_reset", 64'(bus.comp_reset), 64'd1);
    check_eq("mid_rst_ack", 64'(bus.ack), 64'd0);
    check_eq("mid_rst_grant", 64'(bus.grant_id), 64'd0);
    bus.req = 4'b1111;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    n = 0;
    acks = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.ack != '0) acks++;
      if (!bus.comp_reset) break;
      n++;
    end
    check_eq("mid_init_len", 64'(n), 64'(RC));
    check_eq("mid_no_ack", 64'(acks), 64'd0);

    // fairness: all requesting and held, pointer restarted at 0
    prev_c = 0;
    for (int j = 0; j < 5; j++) begin
      do_invocation(4'b1111, 0, RR_D, j % N, 1'b0, RR_D, 1'b0, 1'b1, ack_c);
      if (j > 0) check_eq("rr_spacing", 64'(ack_c - prev_c), 64'(RR_D + 2));
      prev_c = ack_c;
      check_rereset(0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
